// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - PLL lock qualifier, core reset sequencer and VDG/CPU clock-enable generator
module pll_reset_seq #(
    parameter int LOCK_CYCLES = 1024,
    parameter int CE_DIV_VDG  = 14,
    parameter int CE_DIV_CPU  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       sys_rst,
    output logic       ce_vdg,
    output logic       ce_cpu,
    output logic [7:0] lock_loss_cnt
);

    localparam logic [1:0] WAIT_LOCK = 2'd0;
    localparam logic [1:0] STABLE    = 2'd1;
    localparam logic [1:0] RUN       = 2'd2;

    localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES);
    localparam logic [7:0]  VDG_LAST  = 8'(CE_DIV_VDG - 1);
    localparam logic [7:0]  CPU_LAST  = 8'(CE_DIV_CPU - 1);

    logic [1:0]  sync;
    logic        locked_s;
    logic [1:0]  state;
    logic [1:0]  next_state;
    logic [15:0] lock_cnt;
    logic [15:0] next_lock_cnt;
    logic        loss_evt;
    logic [7:0]  vdg_cnt;
    logic [7:0]  cpu_cnt;
    logic        run_next;
    logic        counting;
    logic        vdg_wrap;

    assign locked_s = sync[1];

    // lock_cnt counts locked samples including the one that left WAIT_LOCK,
    // so release lands LOCK_CYCLES clk after that first sample.
    always_comb begin
        next_state    = state;
        next_lock_cnt = lock_cnt;
        loss_evt      = 1'b0;
        case (state)
            WAIT_LOCK: begin
                next_lock_cnt = '0;
                if (locked_s) begin
                    next_state    = STABLE;
                    next_lock_cnt = 16'd1;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    next_state    = WAIT_LOCK;
                    next_lock_cnt = '0;
                end else if (lock_cnt == LOCK_LAST) begin
                    next_state    = RUN;
                    next_lock_cnt = '0;
                end else begin
                    next_lock_cnt = lock_cnt + 16'd1;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    next_state = WAIT_LOCK;
                    loss_evt   = 1'b1;
                end
            end
            default: begin
                next_state    = WAIT_LOCK;
                next_lock_cnt = '0;
            end
        endcase
    end

    // Dividers only advance once RUN is both current and next, so the first
    // ce_vdg lands exactly CE_DIV_VDG clk after release and never straddles exit.
    assign run_next = (next_state == RUN);
    assign counting = run_next && (state == RUN);
    assign vdg_wrap = counting && (vdg_cnt == VDG_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync          <= 2'b00;
            state         <= WAIT_LOCK;
            lock_cnt      <= '0;
            sys_rst       <= 1'b1;
            vdg_cnt       <= '0;
            cpu_cnt       <= '0;
            ce_vdg        <= 1'b0;
            ce_cpu        <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            sync     <= {sync[0], pll_locked};
            state    <= next_state;
            lock_cnt <= next_lock_cnt;
            sys_rst  <= !run_next;
            if (loss_evt && (lock_loss_cnt != 8'hFF)) begin
                lock_loss_cnt <= lock_loss_cnt + 8'd1;
            end
            if (!counting) begin
                vdg_cnt <= '0;
                cpu_cnt <= '0;
            end else if (vdg_wrap) begin
                vdg_cnt <= '0;
                cpu_cnt <= (cpu_cnt == CPU_LAST) ? 8'd0 : cpu_cnt + 8'd1;
            end else begin
                vdg_cnt <= vdg_cnt + 8'd1;
            end
            ce_vdg <= vdg_wrap;
            ce_cpu <= vdg_wrap && (cpu_cnt == CPU_LAST);
        end
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb/tb_pll_reset_seq.sv - randomized self-checking bench for pll_reset_seq against a cadence model
module tb_pll_reset_seq;

    localparam int LOCK = 16;
    localparam int VDIV = 14;
    localparam int CDIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       sys_rst, ce_vdg, ce_cpu;
    logic [7:0] lock_loss_cnt;
    logic       sys_rst_b, ce_vdg_b, ce_cpu_b;
    logic [7:0] lock_loss_cnt_b;

    int n_cmp = 0;
    int n_fail = 0;

    always #10 clk = ~clk;

    pll_reset_seq #(.LOCK_CYCLES(LOCK), .CE_DIV_VDG(VDIV), .CE_DIV_CPU(CDIV)) u0 (
        .clk(clk), .rst(rst), .pll_locked(pll_locked), .sys_rst(sys_rst),
        .ce_vdg(ce_vdg), .ce_cpu(ce_cpu), .lock_loss_cnt(lock_loss_cnt)
    );

    pll_reset_seq #(.LOCK_CYCLES(LOCK), .CE_DIV_VDG(VDIV), .CE_DIV_CPU(1)) u1 (
        .clk(clk), .rst(rst), .pll_locked(pll_locked), .sys_rst(sys_rst_b),
        .ce_vdg(ce_vdg_b), .ce_cpu(ce_cpu_b), .lock_loss_cnt(lock_loss_cnt_b)
    );

    // Model: locked must be seen LOCK+1 samples in a row (after 2-clk sync)
    // to release; while running, pulses fall on multiples of the divide ratios.
    bit  m_d1, m_d2, m_run;
    int  m_streak, m_t, m_loss;
    logic e_sys, e_vdg, e_cpu;
    logic [7:0] e_loss;

    always @(posedge clk) begin
        bit ls;
        if (rst) begin
            m_d1 = 0; m_d2 = 0; m_run = 0; m_streak = 0; m_t = 0; m_loss = 0;
        end else begin
            ls = m_d2; m_d2 = m_d1; m_d1 = pll_locked;
            if (m_run) begin
                if (!ls) begin
                    m_run = 0; m_streak = 0;
                    if (m_loss < 255) m_loss = m_loss + 1;
                end else begin
                    m_t = m_t + 1;
                end
            end else begin
                m_streak = ls ? m_streak + 1 : 0;
                if (m_streak == LOCK + 1) begin
                    m_run = 1; m_t = 0; m_streak = 0;
                end
            end
        end
        e_sys  = !m_run;
        e_vdg  = m_run && (m_t > 0) && (m_t % VDIV == 0);
        e_cpu  = m_run && (m_t > 0) && (m_t % (VDIV * CDIV) == 0);
        e_loss = m_loss[7:0];
    end

    logic [21:0] obs, expv;
    assign obs  = {sys_rst, ce_vdg, ce_cpu, lock_loss_cnt, sys_rst_b, ce_vdg_b, ce_cpu_b, lock_loss_cnt_b};
    assign expv = {e_sys, e_vdg, e_cpu, e_loss, e_sys, e_vdg, e_vdg, e_loss};

    task automatic relock(output int k);
        rst = 1'b1; pll_locked = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        k = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!sys_rst) begin k = i; break; end
        end
    endtask

    task automatic test_reset;
        logic [21:0] want;
        want = {1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0};
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pll_locked = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_cmp++;
            if (obs !== want) begin
                n_fail++; $display("FAIL reset_state cyc=%0d got=%h want=%h", i, obs, want);
            end
        end
    endtask

    task automatic test_lock_qual;
        int fall = -1;
        rst = 1'b0; pll_locked = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL lock_qual_model k=%0d got=%h want=%h", k, obs, expv);
            end
            if (fall < 0 && !sys_rst) fall = k;
        end
        n_cmp++;
        if (fall !== 18) begin n_fail++; $display("FAIL lock_qual_release got=%0d want=18", fall); end
        n_cmp++;
        if (lock_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL lock_qual_loss got=%0d want=0", lock_loss_cnt); end
    endtask

    task automatic test_glitch;
        int fall = -1;
        int g;
        g = $urandom_range(3, 14);
        rst = 1'b1; pll_locked = 1'b0;
        @(negedge clk);
        rst = 1'b0; pll_locked = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL glitch_model k=%0d got=%h want=%h", k, obs, expv);
            end
            if (fall < 0 && !sys_rst) fall = k;
            if (k == g) pll_locked = 1'b0;
            if (k == g + 1) pll_locked = 1'b1;
        end
        n_cmp++;
        if (fall !== g + 20) begin n_fail++; $display("FAIL glitch_release g=%0d got=%0d want=%0d", g, fall, g + 20); end
        n_cmp++;
        if (lock_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL glitch_loss got=%0d want=0", lock_loss_cnt); end
    endtask

    task automatic test_cadence;
        int k;
        relock(k);
        n_cmp++;
        if (k !== 18) begin n_fail++; $display("FAIL cadence_release got=%0d want=18", k); end
        for (int t = 1; t <= 200; t++) begin
            @(negedge clk);
            n_cmp++;
            if ({ce_vdg, ce_cpu} !== {1'(t % VDIV == 0), 1'(t % (VDIV * CDIV) == 0)}) begin
                n_fail++; $display("FAIL cadence_pulse t=%0d got=%b%b", t, ce_vdg, ce_cpu);
            end
            n_cmp++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL cadence_model t=%0d got=%h want=%h", t, obs, expv);
            end
        end
    endtask

    task automatic test_lock_loss;
        int k;
        int jr;
        int first_ce = -1;
        jr = 34 + $urandom_range(0, 5);
        relock(k);
        n_cmp++;
        if (k !== 18) begin n_fail++; $display("FAIL loss_release got=%0d want=18", k); end
        for (int j = 1; j <= 90; j++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL loss_model j=%0d got=%h want=%h", j, obs, expv);
            end
            if (j == 32 && sys_rst !== 1'b0) begin
                n_fail++; $display("FAIL loss_early got=%b want=0", sys_rst);
            end
            if (j == 33) begin
                n_cmp++;
                if ({sys_rst, ce_vdg, ce_cpu, lock_loss_cnt} !== {3'b100, 8'd1}) begin
                    n_fail++; $display("FAIL loss_exit got=%b%b%b cnt=%0d want=100 cnt=1",
                                       sys_rst, ce_vdg, ce_cpu, lock_loss_cnt);
                end
            end
            if (j > 33 && first_ce < 0 && ce_vdg) first_ce = j;
            if (j == 30) pll_locked = 1'b0;
            if (j == jr) pll_locked = 1'b1;
        end
        n_cmp++;
        if (first_ce !== jr + 33) begin n_fail++; $display("FAIL loss_realign got=%0d want=%0d", first_ce, jr + 33); end
    endtask

    task automatic test_saturation;
        int k;
        int hold;
        relock(k);
        for (int n = 0; n < 260; n++) begin
            pll_locked = 1'b0;
            @(negedge clk);
            pll_locked = 1'b1;
            hold = 22 + $urandom_range(0, 6);
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                n_cmp++;
                if (obs !== expv) begin
                    n_fail++; $display("FAIL sat_model n=%0d c=%0d got=%h want=%h", n, c, obs, expv);
                end
            end
        end
        n_cmp++;
        if ({lock_loss_cnt, lock_loss_cnt_b} !== {8'd255, 8'd255}) begin
            n_fail++; $display("FAIL sat_cap got=%0d/%0d want=255", lock_loss_cnt, lock_loss_cnt_b);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (lock_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL sat_clear got=%0d want=0", lock_loss_cnt); end
    endtask

    task automatic test_reset_mid_run;
        int k;
        int fall = -1;
        relock(k);
        for (int j = 1; j <= 160; j++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL midrun_model j=%0d got=%h want=%h", j, obs, expv);
            end
            if (j == 21) begin
                n_cmp++;
                if ({sys_rst, ce_vdg, ce_cpu, sys_rst_b, ce_vdg_b, ce_cpu_b} !== 6'b100100) begin
                    n_fail++; $display("FAIL midrun_reset got=%b%b%b%b%b%b want=100100",
                                       sys_rst, ce_vdg, ce_cpu, sys_rst_b, ce_vdg_b, ce_cpu_b);
                end
            end
            if (j > 21 && fall < 0 && !sys_rst) fall = j;
            if (j > 21) begin
                n_cmp++;
                if (ce_cpu_b !== ce_vdg_b) begin
                    n_fail++; $display("FAIL div1_cpu j=%0d got=%b want=%b", j, ce_cpu_b, ce_vdg_b);
                end
            end
            if (j == 20) rst = 1'b1;
            if (j == 21) rst = 1'b0;
        end
        n_cmp++;
        if (fall !== 40) begin n_fail++; $display("FAIL midrun_rerelease got=%0d want=40", fall); end
    endtask

    initial begin
        rst = 1'b1;
        pll_locked = 1'b0;
        @(negedge clk);
        test_reset();
        test_lock_qual();
        test_glitch();
        test_cadence();
        test_lock_loss();
        test_saturation();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
